// File: rtl/zchunk_compressor.sv
// Two-pass page compressor: scans a 64-line page for all-zero chunks, then writes a
// metadata line followed by only the non-zero chunks, replayed from the read FIFO.
module zchunk_compressor #(
  parameter int unsigned FIFO_PTR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH     = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      comp_start,
  output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
  output logic                      ld_rdfifo_rdptr,
  input  logic                      rdfifo_empty,
  output logic                      rd_req,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic [1:0]                rd_rresp,
  input  logic                      rd_valid,
  input  logic                      wrfifo_full,
  output logic                      wr_req,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [3:0]                zero_chunk_vec,
  output logic [13:0]               comp_size,
  output logic                      comp_done,
  output logic                      bus_error
);

  localparam int unsigned NUM_CHUNKS  = 4;
  localparam int unsigned CHUNK_LINES = 16;
  localparam int unsigned CHUNK_SHIFT = $clog2(CHUNK_LINES);
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned SIZE_W      = 14;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_META, S_SEL, S_XFER, S_DONE, S_BERR
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_CHUNKS-1:0]     nz_q, nz_d;
  logic [NUM_CHUNKS-1:0]     done_q, done_d;
  logic [1:0]                cur_q, cur_d;
  logic                      out_q, out_d;

  logic [FIFO_PTR_WIDTH-1:0] ptr_d;
  logic                      ld_d, rd_req_d, wr_req_d, comp_done_d, bus_error_d;
  logic [DATA_WIDTH-1:0]     wr_data_d;
  logic [3:0]                vec_d;
  logic [SIZE_W-1:0]         size_d;

  logic                      accept, err, can_read, last_scan, last_xfer, sel_found;
  logic [1:0]                sel_idx;
  logic [NUM_CHUNKS-1:0]     pending, nz_upd;
  logic [2:0]                nz_cnt;

  // A response counts only when it answers our single outstanding read.
  assign accept    = rd_valid && out_q;
  assign err       = accept && (rd_rresp != 2'b00);
  assign can_read  = !rdfifo_empty && !out_q && !ld_rdfifo_rdptr;
  assign last_scan = (cnt_q == CNT_W'(63));
  assign last_xfer = (cnt_q[3:0] == 4'hF);
  assign pending   = ~zero_chunk_vec & ~done_q;
  assign nz_upd    = nz_q | (NUM_CHUNKS'(|rd_data) << cnt_q[5:4]);

  // Lowest-numbered non-zero chunk not yet replayed.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(NUM_CHUNKS) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      nz_cnt = nz_cnt + 3'(nz_upd[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (comp_start && !rdfifo_empty) state_d = S_SCAN;
      S_SCAN: begin
        if (err)                    state_d = S_BERR;
        else if (accept && last_scan) state_d = S_META;
      end
      S_META: if (!wrfifo_full) state_d = S_SEL;
      S_SEL:  state_d = sel_found ? S_XFER : S_DONE;
      S_XFER: begin
        if (err)                    state_d = S_BERR;
        else if (accept && last_xfer) state_d = S_SEL;
      end
      S_DONE: if (!comp_start) state_d = S_IDLE;
      S_BERR: state_d = S_BERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_d        = 1'b0;
    ptr_d       = rdfifo_rdptr;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    wr_data_d   = '0;
    vec_d       = zero_chunk_vec;
    size_d      = comp_size;
    comp_done_d = 1'b0;
    bus_error_d = bus_error;
    cnt_d       = cnt_q;
    nz_d        = nz_q;
    done_d      = done_q;
    cur_d       = cur_q;
    case (state_q)
      S_IDLE: begin
        if (comp_start && !rdfifo_empty) begin
          ld_d   = 1'b1;
          ptr_d  = '0;
          cnt_d  = '0;
          nz_d   = '0;
          done_d = '0;
          vec_d  = '0;
          size_d = '0;
        end
      end
      S_SCAN: begin
        rd_req_d = can_read;
        if (err) begin
          bus_error_d = 1'b1;
        end else if (accept) begin
          nz_d  = nz_upd;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_scan) begin
            vec_d  = ~nz_upd;
            size_d = SIZE_W'(1) + (SIZE_W'(nz_cnt) << CHUNK_SHIFT);
          end
        end
      end
      S_META: begin
        if (!wrfifo_full) begin
          wr_req_d  = 1'b1;
          wr_data_d = DATA_WIDTH'(zero_chunk_vec);
        end
      end
      S_SEL: begin
        if (sel_found) begin
          ld_d  = 1'b1;
          ptr_d = FIFO_PTR_WIDTH'(sel_idx) << CHUNK_SHIFT;
          cnt_d = '0;
          cur_d = sel_idx;
        end
      end
      S_XFER: begin
        rd_req_d = can_read && !wrfifo_full;
        if (err) begin
          bus_error_d = 1'b1;
        end else if (accept) begin
          wr_req_d  = 1'b1;
          wr_data_d = rd_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (last_xfer) done_d[cur_q] = 1'b1;
        end
      end
      S_DONE: begin
        comp_done_d = comp_start;
        if (!comp_start) done_d = '0;
      end
      S_BERR: bus_error_d = 1'b1;
      default: ;
    endcase
    out_d = (out_q && !accept) || rd_req_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdfifo_rdptr    <= '0;
      ld_rdfifo_rdptr <= 1'b0;
      rd_req          <= 1'b0;
      wr_req          <= 1'b0;
      wr_data         <= '0;
      zero_chunk_vec  <= '0;
      comp_size       <= '0;
      comp_done       <= 1'b0;
      bus_error       <= 1'b0;
      cnt_q           <= '0;
      nz_q            <= '0;
      done_q          <= '0;
      cur_q           <= '0;
      out_q           <= 1'b0;
    end else begin
      rdfifo_rdptr    <= ptr_d;
      ld_rdfifo_rdptr <= ld_d;
      rd_req          <= rd_req_d;
      wr_req          <= wr_req_d;
      wr_data         <= wr_data_d;
      zero_chunk_vec  <= vec_d;
      comp_size       <= size_d;
      comp_done       <= comp_done_d;
      bus_error       <= bus_error_d;
      cnt_q           <= cnt_d;
      nz_q            <= nz_d;
      done_q          <= done_d;
      cur_q           <= cur_d;
      out_q           <= out_d;
    end
  end

endmodule

// File: tb/tb_zchunk_compressor.sv
// Bench for zchunk_compressor: emulates the read FIFO and checks the write stream,
// pointer loads and status against a page-level model.
module tb_zchunk_compressor;

  localparam int unsigned PW = 6;
  localparam int unsigned DW = 512;

  logic          clk_i;
  logic          rst_ni;
  logic          comp_start;
  logic [PW-1:0] rdfifo_rdptr;
  logic          ld_rdfifo_rdptr;
  logic          rdfifo_empty;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_rresp;
  logic          rd_valid;
  logic          wrfifo_full;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic [3:0]    zero_chunk_vec;
  logic [13:0]   comp_size;
  logic          comp_done;
  logic          bus_error;

  zchunk_compressor #(.FIFO_PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .comp_start(comp_start),
    .rdfifo_rdptr(rdfifo_rdptr), .ld_rdfifo_rdptr(ld_rdfifo_rdptr),
    .rdfifo_empty(rdfifo_empty), .rd_req(rd_req), .rd_data(rd_data),
    .rd_rresp(rd_rresp), .rd_valid(rd_valid), .wrfifo_full(wrfifo_full),
    .wr_req(wr_req), .wr_data(wr_data), .zero_chunk_vec(zero_chunk_vec),
    .comp_size(comp_size), .comp_done(comp_done), .bus_error(bus_error)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] page [64];
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] exp_ws[$];
  int            ld_log[$];
  int            exp_ld[$];
  logic [3:0]    exp_vec;
  int            exp_nz;
  int            rptr, rd_count, err_idx, pend_dly, full_hold, n;
  int            checks, failures;
  logic          pend_valid, ld_prev, done_seen, noise, full_used, drop_start;
  logic [DW-1:0] pend_data;
  logic [1:0]    pend_resp;

  task automatic chk_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Chunks whose mask bit is set are all zero; the others hold sparse random lines.
  function automatic void fill_page(input logic [3:0] zmask);
    for (int i = 0; i < 64; i++) begin
      if (zmask[i/16] || ($urandom_range(0, 1) == 0)) page[i] = '0;
      else                                            page[i] = rand_line();
    end
  endfunction

  // Expected output derived directly from the page contents.
  function automatic void build_exp();
    exp_ws.delete();
    exp_ld.delete();
    exp_nz = 0;
    for (int c = 0; c < 4; c++) begin
      exp_vec[c] = 1'b1;
      for (int l = 0; l < 16; l++) if (page[c*16 + l] != '0) exp_vec[c] = 1'b0;
    end
    exp_ws.push_back({508'b0, exp_vec});
    exp_ld.push_back(0);
    for (int c = 0; c < 4; c++) begin
      if (!exp_vec[c]) begin
        exp_nz++;
        exp_ld.push_back(16 * c);
        for (int l = 0; l < 16; l++) exp_ws.push_back(page[c*16 + l]);
      end
    end
  endfunction

  // One clock: protocol checks, FIFO emulation, input noise.
  task automatic step();
    @(negedge clk_i);
    if (comp_done) begin
      done_seen = 1'b1;
      chk_int("done_needs_start", 32'(comp_start), 32'd1);
    end
    if (rd_req)
      chk_int("rd_gate", 32'({rdfifo_empty, wrfifo_full, ld_rdfifo_rdptr, ld_prev, pend_valid}), 32'd0);
    ld_prev = ld_rdfifo_rdptr;
    if (ld_rdfifo_rdptr) begin
      ld_log.push_back(int'(rdfifo_rdptr));
      rptr = int'(rdfifo_rdptr);
    end
    if (wr_req) wr_log.push_back(wr_data);
    rd_valid = 1'b0;
    rd_rresp = 2'b00;
    rd_data  = '0;
    if (pend_valid) begin
      if (pend_dly == 0) begin
        rd_valid   = 1'b1;
        rd_data    = pend_data;
        rd_rresp   = pend_resp;
        pend_valid = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    if (rd_req) begin
      pend_data  = page[rptr % 64];
      pend_resp  = (rd_count == err_idx) ? 2'd2 : 2'd0;
      pend_valid = 1'b1;
      pend_dly   = $urandom_range(0, 2);
      rd_count++;
      rptr++;
    end
    rdfifo_empty = noise && ($urandom_range(0, 3) == 0);
    if (noise && !full_used && wr_log.size() >= 20) begin
      full_hold = 10;
      full_used = 1'b1;
    end
    if (full_hold > 0) begin
      wrfifo_full = 1'b1;
      full_hold--;
    end else begin
      wrfifo_full = 1'b0;
    end
    if (drop_start) comp_start = !(rd_count >= 3 && rd_count < 40);
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    comp_start   = 1'b0;
    pend_valid   = 1'b0;
    rd_valid     = 1'b0;
    rd_rresp     = 2'b00;
    wrfifo_full  = 1'b0;
    rdfifo_empty = 1'b0;
    step();
    step();
    chk_int("rst_ptr", 32'(rdfifo_rdptr), 32'd0);
    chk_int("rst_ld", 32'(ld_rdfifo_rdptr), 32'd0);
    chk_int("rst_rd_req", 32'(rd_req), 32'd0);
    chk_int("rst_wr_req", 32'(wr_req), 32'd0);
    chk_wide("rst_wr_data", wr_data, '0);
    chk_int("rst_vec", 32'(zero_chunk_vec), 32'd0);
    chk_int("rst_size", 32'(comp_size), 32'd0);
    chk_int("rst_done", 32'(comp_done), 32'd0);
    chk_int("rst_bus_error", 32'(bus_error), 32'd0);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic run_page(input string tag, input logic drop);
    build_exp();
    wr_log.delete();
    ld_log.delete();
    rd_count   = 0;
    done_seen  = 1'b0;
    full_used  = 1'b0;
    drop_start = drop;
    comp_start = 1'b1;
    n = 0;
    while (!comp_done && n < 20000) begin
      step();
      n++;
    end
    chk_int({tag, "_done"}, 32'(comp_done), 32'd1);
    chk_int({tag, "_vec"}, 32'(zero_chunk_vec), 32'(exp_vec));
    chk_int({tag, "_size"}, 32'(comp_size), 32'(1 + 16 * exp_nz));
    chk_int({tag, "_reads"}, 32'(rd_count), 32'(64 + 16 * exp_nz));
    chk_int({tag, "_nwrites"}, 32'(wr_log.size()), 32'(exp_ws.size()));
    for (int i = 0; i < exp_ws.size() && i < wr_log.size(); i++)
      chk_wide($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_ws[i]);
    chk_int({tag, "_nld"}, 32'(ld_log.size()), 32'(exp_ld.size()));
    for (int i = 0; i < exp_ld.size() && i < ld_log.size(); i++)
      chk_int($sformatf("%s_ld%0d", tag, i), 32'(ld_log[i]), 32'(exp_ld[i]));
    drop_start = 1'b0;
    comp_start = 1'b0;
    repeat (3) step();
    chk_int({tag, "_done_clr"}, 32'(comp_done), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rptr = 0; rd_count = 0; err_idx = -1; pend_dly = 0; full_hold = 0; n = 0;
    pend_valid = 1'b0; ld_prev = 1'b0; done_seen = 1'b0;
    noise = 1'b0; full_used = 1'b0; drop_start = 1'b0;
    pend_data = '0; pend_resp = 2'b00; exp_vec = '0; exp_nz = 0;
    rst_ni = 1'b0; comp_start = 1'b0; rdfifo_empty = 1'b0; wrfifo_full = 1'b0;
    rd_valid = 1'b0; rd_rresp = 2'b00; rd_data = '0;
    for (int i = 0; i < 64; i++) page[i] = '0;

    do_reset();

    // Unsolicited error response while idle must be ignored.
    rd_valid = 1'b1; rd_rresp = 2'd2; rd_data = '1;
    @(negedge clk_i);
    @(negedge clk_i);
    rd_valid = 1'b0; rd_rresp = 2'b00; rd_data = '0;
    @(negedge clk_i);
    chk_int("stray_valid_bus_error", 32'(bus_error), 32'd0);
    chk_int("stray_valid_rd_req", 32'(rd_req), 32'd0);

    for (int i = 0; i < 64; i++) page[i] = '0;
    run_page("all_zero", 1'b0);

    for (int i = 0; i < 64; i++) page[i] = {64{8'hA5}};
    run_page("all_a5", 1'b0);

    for (int i = 0; i < 64; i++) page[i] = '0;
    for (int i = 0; i < 16; i++) begin
      page[i] = rand_line();
      page[i][0] = 1'b1;
    end
    page[47][511] = 1'b1;
    run_page("chunk13_zero", 1'b0);

    noise = 1'b1;
    for (int i = 0; i < 64; i++) page[i] = {64{8'hA5}};
    run_page("a5_backpressure", 1'b0);
    noise = 1'b0;

    fill_page(4'($urandom_range(0, 15)));
    run_page("random_a", 1'b0);
    fill_page(4'b0001);
    run_page("start_drop", 1'b1);

    // Error response on the 21st scan line.
    fill_page(4'b0000);
    page[5] = rand_line();
    err_idx = 20;
    wr_log.delete(); ld_log.delete(); rd_count = 0; done_seen = 1'b0;
    comp_start = 1'b1;
    n = 0;
    while (!bus_error && n < 5000) begin
      step();
      n++;
    end
    repeat (100) step();
    chk_int("berr_flag", 32'(bus_error), 32'd1);
    chk_int("berr_reads", 32'(rd_count), 32'd21);
    chk_int("berr_writes", 32'(wr_log.size()), 32'd0);
    chk_int("berr_done_seen", 32'(done_seen), 32'd0);
    err_idx = -1;
    do_reset();

    // Reset during chunk replay, then a fresh page.
    fill_page(4'b0000);
    page[0] = rand_line();
    wr_log.delete(); ld_log.delete(); rd_count = 0;
    comp_start = 1'b1;
    n = 0;
    while (wr_log.size() < 10 && n < 20000) begin
      step();
      n++;
    end
    chk_int("mid_xfer_reached", 32'(wr_log.size() >= 10), 32'd1);
    do_reset();
    fill_page(4'b0100);
    run_page("after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
